mmio_io_ctrl: RTL

//  Memory-mapped I/O controller for the 151 core. It decodes data-side accesses with addr[31]=1 and

---
 rtl/mmio_io_ctrl_pkg.sv | 31 +++
 rtl/mmio_io_ctrl_sync_fifo.sv | 58 +++++
 rtl/mmio_io_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the MMIO I/O controller: base bit, register offsets and status bit layout.
// Software tests use the same offsets and status bit indices.
package mmio_io_ctrl_pkg;

    localparam int MMIO_BASE_BIT = 31;

    typedef enum logic [7:0] {
        OFF_STATUS = 8'h00,
        OFF_RX     = 8'h04,
        OFF_TX     = 8'h08,
        OFF_LEVEL  = 8'h0C,
        OFF_CYC    = 8'h10,
        OFF_INST   = 8'h14,
        OFF_CLR    = 8'h18
    } mmio_off_e;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_TX_OVF       = 2;

    function automatic logic [31:0] statusWord(input logic ovf, input logic rxNotEmpty,
                                               input logic txNotFull);
        logic [31:0] w;
        w                    = 32'b0;
        w[STAT_TX_OVF]       = ovf;
        w[STAT_RX_NOT_EMPTY] = rxNotEmpty;
        w[STAT_TX_NOT_FULL]  = txNotFull;
        return w;
    endfunction

endpackage

// File: rtl/mmio_io_ctrl_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter so all DEPTH slots are usable.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module mmio_io_ctrl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: address decode, UART RX/TX byte FIFOs, cycle/instruction counters.
// Load data is registered one cycle after the request, matching dmem latency.
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int RX_DEPTH  = 8,
    parameter int TX_DEPTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_wbe,
    input  logic        i_req_re,
    output logic        o_mmio_hit,
    output logic [31:0] o_rdata,
    input  logic        i_inst_retired,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);

    logic                      w_hit;
    logic [7:0]                w_off;
    logic                      w_rdEn;
    logic                      w_wrEn;
    logic                      w_rxPush;
    logic                      w_rxPop;
    logic                      w_rxFull;
    logic                      w_rxEmpty;
    logic [7:0]                w_rxHead;
    logic [$clog2(RX_DEPTH):0] w_rxCount;
    logic                      w_txWrite;
    logic                      w_txPush;
    logic                      w_txPop;
    logic                      w_txFull;
    logic                      w_txEmpty;
    logic [$clog2(TX_DEPTH):0] w_txCount;
    logic                      w_cntClr;
    logic [31:0]               w_rdNext;
    logic                      w_unused;
    logic                      r_txOvf;
    logic [CNT_WIDTH-1:0]      r_cycCnt;
    logic [CNT_WIDTH-1:0]      r_instCnt;
    logic [31:0]               r_rdata;

    assign w_hit     = i_req_addr[MMIO_BASE_BIT];
    assign w_off     = i_req_addr[7:0];
    assign w_rdEn    = w_hit && i_req_re;
    assign w_wrEn    = w_hit && (|i_req_wbe);
    assign w_unused  = &{1'b0, i_req_addr[30:8], i_req_wdata[31:8]};

    // A pop frees a slot in the same cycle, so a full RX FIFO still takes the incoming byte then.
    assign w_rxPop   = w_rdEn && (w_off == OFF_RX) && !w_rxEmpty;
    assign w_rxPush  = i_rx_valid && (!w_rxFull || w_rxPop);

    assign w_txPop   = !w_txEmpty && i_tx_ready;
    assign w_txWrite = w_hit && i_req_wbe[0] && (w_off == OFF_TX);
    assign w_txPush  = w_txWrite && (!w_txFull || w_txPop);
    assign w_cntClr  = w_wrEn && (w_off == OFF_CLR);

    mmio_io_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) uRxFifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rxPush),
        .i_pop   (w_rxPop),
        .i_data  (i_rx_data),
        .o_head  (w_rxHead),
        .o_full  (w_rxFull),
        .o_empty (w_rxEmpty),
        .o_count (w_rxCount)
    );

    mmio_io_ctrl_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) uTxFifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_txPush),
        .i_pop   (w_txPop),
        .i_data  (i_req_wdata[7:0]),
        .o_head  (o_tx_data),
        .o_full  (w_txFull),
        .o_empty (w_txEmpty),
        .o_count (w_txCount)
    );

    always_comb begin
        w_rdNext = 32'b0;
        if (w_rdEn) begin
            case (w_off)
                OFF_STATUS: w_rdNext = statusWord(r_txOvf, !w_rxEmpty, !w_txFull);
                OFF_RX:     w_rdNext = w_rxEmpty ? 32'b0 : {24'b0, w_rxHead};
                OFF_LEVEL:  w_rdNext = {16'b0, 8'(w_txCount), 8'(w_rxCount)};
                OFF_CYC:    w_rdNext = 32'(r_cycCnt);
                OFF_INST:   w_rdNext = 32'(r_instCnt);
                default:    w_rdNext = 32'b0;
            endcase
        end
    end

    // Overflow is sticky until software writes the status register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_txOvf   <= 1'b0;
            r_cycCnt  <= '0;
            r_instCnt <= '0;
            r_rdata   <= 32'b0;
        end else begin
            r_rdata <= w_rdNext;
            if (w_wrEn && (w_off == OFF_STATUS)) begin
                r_txOvf <= 1'b0;
            end else if (w_txWrite && !w_txPush) begin
                r_txOvf <= 1'b1;
            end
            if (w_cntClr) begin
                r_cycCnt  <= '0;
                r_instCnt <= '0;
            end else begin
                r_cycCnt  <= r_cycCnt + CNT_WIDTH'(1);
                r_instCnt <= r_instCnt + CNT_WIDTH'(i_inst_retired);
            end
        end
    end

    assign o_mmio_hit = w_hit;
    assign o_rdata    = r_rdata;
    assign o_rx_ready = !w_rxFull;
    assign o_tx_valid = !w_txEmpty;

endmodule
